// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and helpers for sync_fifo_ext
//
// Contents:
//   fifo_mode_e : read-side behaviour, registered (FIFO_STD) or show-ahead (FIFO_FWFT)
//   ptr_inc     : pointer increment with explicit wrap, valid for any depth

package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Wraps from depth-1 back to 0, so non-power-of-two depths need no spare MSB.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - storage array for sync_fifo_ext
//
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. Deliberately has no reset so it maps onto RAM.
//
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address, 0..DEPTH-1
//   wdata : write data
//   raddr : read address, 0..DEPTH-1
//   rdata : combinational read data

module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - parametrised single-clock FIFO with thresholds, FWFT and error flags
//
// Ports:
//   clk          : rising-edge clock for all state
//   reset        : asynchronous, active-high reset
//   flush        : synchronous clear of pointers, count, error flags and rd_valid
//   wr_en        : write request, accepted when not full
//   data_in      : write data
//   rd_en        : read request (pop acknowledge in FWFT), accepted when not empty
//   data_out     : read data (registered in FIFO_STD, head of queue in FIFO_FWFT)
//   rd_valid     : FIFO_STD: data_out was popped last edge; FIFO_FWFT: head valid
//   count        : number of stored entries
//   full / almost_full / empty / almost_empty : status decoded from count
//   overflow / underflow : sticky, cleared by reset or flush

module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 2,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    // Guarded so an illegal DEPTH still reaches the elaboration checks below
    // instead of tripping over a zero-width pointer first.
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_ext: DEPTH must be at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_ext: AF_THRESH must lie in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_ext: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance looks only at the registered count: a write into a full FIFO
    // is dropped even if a read frees a slot on the same edge.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head of queue is presented directly; zero when nothing is stored so
        // stale array contents never leak out.
        assign data_out = empty ? '0 : rd_data;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        // data_q holds across flush and idle cycles; only a real pop updates it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= rd_data;
                end
            end
        end

        assign data_out = data_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - directed self-checking bench for sync_fifo_ext

module tb_sync_fifo_ext;
    import sync_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_data, f_data;
    logic       s_valid, f_valid;
    logic [2:0] s_count, f_count;
    logic       s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
    logic       f_full, f_af, f_empty, f_ae, f_ovf, f_udf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(
        .DATA_WIDTH (8), .DEPTH (5), .AF_THRESH (4), .AE_THRESH (1), .MODE (FIFO_STD)
    ) u_std (
        .clk (clk), .reset (reset), .flush (flush), .wr_en (wr_en), .data_in (data_in),
        .rd_en (rd_en), .data_out (s_data), .rd_valid (s_valid), .count (s_count),
        .full (s_full), .almost_full (s_af), .empty (s_empty), .almost_empty (s_ae),
        .overflow (s_ovf), .underflow (s_udf)
    );

    sync_fifo_ext #(
        .DATA_WIDTH (8), .DEPTH (5), .AF_THRESH (4), .AE_THRESH (1), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk (clk), .reset (reset), .flush (flush), .wr_en (wr_en), .data_in (data_in),
        .rd_en (rd_en), .data_out (f_data), .rd_valid (f_valid), .count (f_count),
        .full (f_full), .almost_full (f_af), .empty (f_empty), .almost_empty (f_ae),
        .overflow (f_ovf), .underflow (f_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        data_in = '0;
    endtask

    initial begin
        // Reset state while reset is held
        #3;
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_af", 32'(s_af), 0);
        check("rst_ovf", 32'(s_ovf), 0);
        check("rst_udf", 32'(s_udf), 0);
        check("rst_data", 32'(s_data), 0);
        check("rst_valid", 32'(s_valid), 0);
        check("rst_fwft_data", 32'(f_data), 0);
        check("rst_fwft_valid", 32'(f_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill: 0x11..0x55, almost_full at 4, full at 5
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
            check("fill_count", 32'(s_count), 32'(i));
            check("fill_af", 32'(s_af), 32'(i >= 4));
            check("fill_full", 32'(s_full), 32'(i == 5));
            check("fill_ae", 32'(s_ae), 32'(i <= 1));
            check("fill_empty", 32'(s_empty), 0);
        end
        check("fwft_head_11", 32'(f_data), 32'h11);

        // Sixth write is dropped
        cyc(1'b1, 8'h66, 1'b0, 1'b0);
        check("ovf_count", 32'(s_count), 5);
        check("ovf_flag", 32'(s_ovf), 1);
        check("ovf_udf_clear", 32'(s_udf), 0);

        // Full with wr+rd: only the read happens
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_rw_count", 32'(s_count), 4);
        check("full_rw_ovf", 32'(s_ovf), 1);
        check("full_rw_data", 32'(s_data), 32'h11);
        check("full_rw_valid", 32'(s_valid), 1);
        check("full_rw_fwft_head", 32'(f_data), 32'h22);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("rd_22_data", 32'(s_data), 32'h22);
        check("rd_22_count", 32'(s_count), 3);

        // Flush at count 3 with overflow set, alongside a write
        cyc(1'b1, 8'h99, 1'b0, 1'b1);
        check("flush_count", 32'(s_count), 0);
        check("flush_empty", 32'(s_empty), 1);
        check("flush_ovf", 32'(s_ovf), 0);
        check("flush_valid", 32'(s_valid), 0);
        check("flush_data_hold", 32'(s_data), 32'h22);
        check("flush_fwft_data", 32'(f_data), 0);
        check("flush_fwft_valid", 32'(f_valid), 0);

        // Empty with wr+rd: only the write happens; FWFT shows it at once
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        check("empty_rw_count", 32'(s_count), 1);
        check("empty_rw_udf", 32'(s_udf), 1);
        check("empty_rw_valid", 32'(s_valid), 0);
        check("fwft_a5_data", 32'(f_data), 32'hA5);
        check("fwft_a5_valid", 32'(f_valid), 1);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_pop_data", 32'(f_data), 0);
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_valid", 32'(f_valid), 0);
        check("std_pop_a5", 32'(s_data), 32'hA5);
        check("udf_sticky", 32'(s_udf), 1);

        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_udf", 32'(s_udf), 0);

        // Count 2 with wr+rd: count stays
        cyc(1'b1, 8'hB0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b1, 1'b0);
        check("mid_rw_count", 32'(s_count), 2);
        check("mid_rw_data", 32'(s_data), 32'hB0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_b1", 32'(s_data), 32'hB1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_b2", 32'(s_data), 32'hB2);
        check("drain_empty", 32'(s_empty), 1);

        // Wrap: 12 write/read pairs, pointers cross 4->0 several times
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check("wrap_valid_low", 32'(s_valid), 0);
            check("wrap_fwft_head", 32'(f_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_data", 32'(s_data), 32'(i));
            check("wrap_valid", 32'(s_valid), 1);
            check("wrap_count", 32'(s_count), 0);
        end

        // Async reset mid-stream at count 4
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        check("pre_rst_count", 32'(s_count), 4);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(s_count), 0);
        check("async_rst_empty", 32'(s_empty), 1);
        check("async_rst_fwft_data", 32'(f_data), 0);
        #2;
        reset = 1'b0;
        cyc(1'b1, 8'hD7, 1'b0, 1'b0);
        check("post_rst_count", 32'(s_count), 1);
        check("post_rst_fwft", 32'(f_data), 32'hD7);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", 32'(s_data), 32'hD7);
        check("post_rst_valid", 32'(s_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
